// File: rtl/hazard_pkg.sv
// Purpose: shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULBUSY = 2'd1,
    MEMWAIT = 2'd2
  } hz_state_t;

  // X31 reads as zero, so it can never carry a real dependency.
  localparam logic [4:0] XZR = 5'd31;

  // Width of the multiply down-counter; bounds MUL_LATENCY to 2..15.
  localparam int MULCNT_W = 4;

endpackage

// File: rtl/stall_counter.sv
// Purpose: saturating 32-bit event counter with enable and synchronous clear.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; holds at 32'hFFFF_FFFF instead of wrapping.
// Ports: clk, clr (sync clear, wins over en), en (count this cycle), count.
// The module body only exists when HAZARD_PERF_EN is defined, so the
// default build carries no counter at all.
`ifdef HAZARD_PERF_EN
module stall_counter (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= 32'd0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/hazard_unit.sv
// Purpose: stall/flush controller for the five-stage pipeline (load-use,
//          multi-cycle multiply, data-memory wait, taken-branch flush).
// Latency: all outputs combinational from state and inputs; state on clk.
// Backpressure: memory wait freezes the whole pipe (pipestall), multiply
//          freezes the front (PCwrite/IFIDwrite), load-use inserts a bubble.
// Ports: clk, reset (sync, active-high); EX-stage info IDEXmemread/IDEXmul/
//          IDEXrd; ID-stage sources IFIDrn/IFIDrm/IFIDusesrm; branchtaken;
//          EXMEMmemaccess/memready; outputs PCwrite, IFIDwrite, IDEXbubble,
//          IFIDflush, IDEXflush, pipestall, and stallcycles when
//          HAZARD_PERF_EN is defined.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IDEXmemread,
  input  logic       IDEXmul,
  input  logic [4:0] IDEXrd,
  input  logic [4:0] IFIDrn,
  input  logic [4:0] IFIDrm,
  input  logic       IFIDusesrm,
  input  logic       branchtaken,
  input  logic       EXMEMmemaccess,
  input  logic       memready,
  output logic       PCwrite,
  output logic       IFIDwrite,
  output logic       IDEXbubble,
  output logic       IFIDflush,
  output logic       IDEXflush,
  output logic       pipestall
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stallcycles
`endif
);

  if ((MUL_LATENCY < 2) || (MUL_LATENCY > 15)) begin : g_bad_latency
    $fatal(1, "hazard_unit: MUL_LATENCY must be in 2..15");
  end

  // The RUN-state cycle that starts the multiply is the first hold cycle,
  // so the counter covers the remaining MUL_LATENCY-2 before release.
  localparam logic [MULCNT_W-1:0] MUL_LOAD = MULCNT_W'(MUL_LATENCY - 2);

  hz_state_t             state, state_nxt;
  logic [MULCNT_W-1:0]   mulcnt, mulcnt_nxt;
  logic                  ret_mul, ret_mul_nxt;  // MEMWAIT returns to MULBUSY
  logic                  memwait;
  logic                  loaduse;
  logic                  do_run;

  assign memwait = EXMEMmemaccess & ~memready;
  assign loaduse = IDEXmemread && (IDEXrd != XZR) &&
                   ((IDEXrd == IFIDrn) || (IFIDusesrm && (IDEXrd == IFIDrm)));

  always_comb begin
    PCwrite     = 1'b1;
    IFIDwrite   = 1'b1;
    IDEXbubble  = 1'b0;
    IFIDflush   = 1'b0;
    IDEXflush   = 1'b0;
    pipestall   = 1'b0;
    state_nxt   = state;
    mulcnt_nxt  = mulcnt;
    ret_mul_nxt = ret_mul;
    do_run      = 1'b0;

    case (state)
      RUN: begin
        if (memwait) begin
          pipestall   = 1'b1;
          PCwrite     = 1'b0;
          IFIDwrite   = 1'b0;
          ret_mul_nxt = 1'b0;
          state_nxt   = MEMWAIT;
        end else begin
          do_run = 1'b1;
        end
      end
      MULBUSY: begin
        // A branch cannot be in EX here, so branchtaken is not examined.
        if (memwait) begin
          pipestall   = 1'b1;
          PCwrite     = 1'b0;
          IFIDwrite   = 1'b0;
          ret_mul_nxt = 1'b1;
          state_nxt   = MEMWAIT;
        end else if (mulcnt == '0) begin
          state_nxt = RUN;
        end else begin
          PCwrite    = 1'b0;
          IFIDwrite  = 1'b0;
          mulcnt_nxt = mulcnt - 1'b1;
        end
      end
      MEMWAIT: begin
        if (!memready) begin
          pipestall = 1'b1;
          PCwrite   = 1'b0;
          IFIDwrite = 1'b0;
        end else if (ret_mul) begin
          // Release cycle frees everything; the saved count resumes next cycle.
          state_nxt = MULBUSY;
        end else begin
          // EX was frozen, so a branch or multiply held there acts now.
          state_nxt = RUN;
          do_run    = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    if (do_run) begin
      if (IDEXmul) begin
        PCwrite    = 1'b0;
        IFIDwrite  = 1'b0;
        mulcnt_nxt = MUL_LOAD;
        state_nxt  = MULBUSY;
      end else if (branchtaken) begin
        // Any load-use match here belongs to the wrong path.
        IFIDflush = 1'b1;
        IDEXflush = 1'b1;
      end else if (loaduse) begin
        PCwrite    = 1'b0;
        IFIDwrite  = 1'b0;
        IDEXbubble = 1'b1;
      end
    end

    if (reset) begin
      PCwrite    = 1'b0;
      IFIDwrite  = 1'b0;
      IDEXbubble = 1'b0;
      IFIDflush  = 1'b1;
      IDEXflush  = 1'b1;
      pipestall  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      mulcnt  <= '0;
      ret_mul <= 1'b0;
    end else begin
      state   <= state_nxt;
      mulcnt  <= mulcnt_nxt;
      ret_mul <= ret_mul_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  stall_counter u_stall_counter (
    .clk   (clk),
    .clr   (reset),
    .en    (~PCwrite & ~reset),
    .count (stallcycles)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Purpose: directed, table-driven self-check of hazard_unit.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpressure: n/a.
module tb_hazard_unit;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       IDEXmemread, mul_a, mul_b;
  logic [4:0] IDEXrd, IFIDrn, IFIDrm;
  logic       IFIDusesrm, branchtaken, EXMEMmemaccess, memready;

  logic pcw_a, ifw_a, bub_a, iff_a, idf_a, stl_a;
  logic pcw_b, ifw_b, bub_b, iff_b, idf_b, stl_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] sc_a, sc_b;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MUL_LATENCY(3)) dut_a (
    .clk(clk), .reset(reset), .IDEXmemread(IDEXmemread), .IDEXmul(mul_a),
    .IDEXrd(IDEXrd), .IFIDrn(IFIDrn), .IFIDrm(IFIDrm), .IFIDusesrm(IFIDusesrm),
    .branchtaken(branchtaken), .EXMEMmemaccess(EXMEMmemaccess),
    .memready(memready), .PCwrite(pcw_a), .IFIDwrite(ifw_a),
    .IDEXbubble(bub_a), .IFIDflush(iff_a), .IDEXflush(idf_a), .pipestall(stl_a)
`ifdef HAZARD_PERF_EN
    , .stallcycles(sc_a)
`endif
  );

  hazard_unit #(.MUL_LATENCY(5)) dut_b (
    .clk(clk), .reset(reset), .IDEXmemread(IDEXmemread), .IDEXmul(mul_b),
    .IDEXrd(IDEXrd), .IFIDrn(IFIDrn), .IFIDrm(IFIDrm), .IFIDusesrm(IFIDusesrm),
    .branchtaken(branchtaken), .EXMEMmemaccess(EXMEMmemaccess),
    .memready(memready), .PCwrite(pcw_b), .IFIDwrite(ifw_b),
    .IDEXbubble(bub_b), .IFIDflush(iff_b), .IDEXflush(idf_b), .pipestall(stl_b)
`ifdef HAZARD_PERF_EN
    , .stallcycles(sc_b)
`endif
  );

  // Output bundle order: {PCwrite, IFIDwrite, IDEXbubble, IFIDflush, IDEXflush, pipestall}
  localparam logic [5:0] O_DEF  = 6'b110000;
  localparam logic [5:0] O_LU   = 6'b001000;
  localparam logic [5:0] O_RST  = 6'b000110;
  localparam logic [5:0] O_BR   = 6'b110110;
  localparam logic [5:0] O_MEM  = 6'b000001;
  localparam logic [5:0] O_HOLD = 6'b000000;

  typedef struct {
    string      name;
    logic       rst;
    logic       memread;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       usesrm;
    logic       br;
    logic       acc;
    logic       rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; IDEXmemread = 1'b0; mul_a = 1'b0; mul_b = 1'b0;
    IDEXrd = 5'd0; IFIDrn = 5'd0; IFIDrm = 5'd0; IFIDusesrm = 1'b0;
    branchtaken = 1'b0; EXMEMmemaccess = 1'b0; memready = 1'b0;
  endtask

  // Sample dut_a outputs mid-cycle, then advance to just after the next edge.
  task automatic step_a(input string name, input logic [5:0] exp);
    @(negedge clk);
    check(name, {26'd0, pcw_a, ifw_a, bub_a, iff_a, idf_a, stl_a}, {26'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic step_b(input string name, input logic [5:0] exp);
    @(negedge clk);
    check(name, {26'd0, pcw_b, ifw_b, bub_b, iff_b, idf_b, stl_b}, {26'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    //         name           rst mr rd     rn     rm     urm br acc rdy exp
    vecs[0]  = '{"reset",      1, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 0, O_RST};
    vecs[1]  = '{"idle",       0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_DEF};
    vecs[2]  = '{"lu_rn",      0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, O_LU};
    vecs[3]  = '{"lu_cleared", 0, 0, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, O_DEF};
    vecs[4]  = '{"lu_rn_xzr",  0, 1, 5'd31,5'd31,5'd0, 0, 0, 0, 0, O_DEF};
    vecs[5]  = '{"rm_ungated", 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, O_DEF};
    vecs[6]  = '{"rm_gated",   0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0, O_LU};
    vecs[7]  = '{"rm_xzr",     0, 1, 5'd31,5'd1, 5'd31,1, 0, 0, 0, O_DEF};
    vecs[8]  = '{"lu_no_match",0, 1, 5'd5, 5'd6, 5'd4, 1, 0, 0, 0, O_DEF};
    vecs[9]  = '{"br_over_lu", 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0, O_BR};
    vecs[10] = '{"mem_same_rdy",0,0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, O_DEF};

    idle();
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      idle();
      reset          = vecs[i].rst;
      IDEXmemread    = vecs[i].memread;
      IDEXrd         = vecs[i].rd;
      IFIDrn         = vecs[i].rn;
      IFIDrm         = vecs[i].rm;
      IFIDusesrm     = vecs[i].usesrm;
      branchtaken    = vecs[i].br;
      EXMEMmemaccess = vecs[i].acc;
      memready       = vecs[i].rdy;
      step_a(vecs[i].name, vecs[i].exp);
    end

    // Multiply, latency 3: front held 2 cycles; EX keeps the op 3 cycles.
    for (int c = 0; c < 4; c++) begin
      idle();
      mul_a = (c < 3);
      step_a($sformatf("mul3_c%0d", c), (c < 2) ? O_HOLD : O_DEF);
    end

    // Multiply, latency 5: front held 4 cycles.
    for (int c = 0; c < 6; c++) begin
      idle();
      mul_b = (c < 5);
      step_b($sformatf("mul5_c%0d", c), (c < 4) ? O_HOLD : O_DEF);
    end

    // Branch held in EX during memory wait is acted on at release.
    idle(); branchtaken = 1'b1; EXMEMmemaccess = 1'b1;
    step_a("br_memwait_c0", O_MEM);
    memready = 1'b1;
    step_a("br_memwait_rel", O_BR);
    idle();
    step_a("br_memwait_after", O_DEF);

    // Memory wait at the second MULBUSY cycle, memready after 3 stall cycles.
    idle(); reset = 1'b1;
    step_a("rst_before_mw", O_RST);
    for (int c = 0; c < 8; c++) begin
      logic [5:0] e;
      idle();
      mul_a          = (c < 7);
      EXMEMmemaccess = (c >= 2) && (c <= 5);
      memready       = (c == 5);
      case (c)
        0, 1:    e = O_HOLD;
        2, 3, 4: e = O_MEM;
        default: e = O_DEF;
      endcase
      step_a($sformatf("mul_mw_c%0d", c), e);
    end
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    check("stallcycles_mul_mw", sc_a, 32'd5);
    @(posedge clk); #1;
`endif

    // Reset mid-MEMWAIT.
    idle(); EXMEMmemaccess = 1'b1;
    step_a("rst_mw_c0", O_MEM);
    step_a("rst_mw_c1", O_MEM);
    reset = 1'b1;
    step_a("rst_mw_reset", O_RST);
    idle();
    step_a("rst_mw_after", O_DEF);
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    check("stallcycles_after_rst", sc_a, 32'd0);
    @(posedge clk); #1;
`endif

    // Reset mid-MULBUSY leaves no residual stall.
    idle(); mul_b = 1'b1;
    step_b("rst_mul_c0", O_HOLD);
    step_b("rst_mul_c1", O_HOLD);
    reset = 1'b1;
    step_b("rst_mul_reset", O_RST);
    idle();
    step_b("rst_mul_after", O_DEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
